// File: rtl/sat_pkg.sv
// Shared SAT-engine types: literal/clause widths and the packed clause type.
// Used by the distribution unit and by each per-engine receive block.
package sat_pkg;

  localparam int unsigned LIT_IDX_MAX     = 1024;
  localparam int unsigned CLA_LENGTH      = 3;
  localparam int unsigned VARIABLE_LENGTH = $clog2(LIT_IDX_MAX) + 1;
  localparam int unsigned NUM_ENGINE      = 4;
  localparam int unsigned CLAUSE_W        = CLA_LENGTH * VARIABLE_LENGTH;

  typedef logic signed [VARIABLE_LENGTH-1:0] lit_t;
  // Literal 0 sits in the LSBs.
  typedef lit_t [CLA_LENGTH-1:0] clause_t;

endpackage

// File: rtl/clause_fifo.sv
// Clause storage FIFO with explicit occupancy count and synchronous flush.
// A push is accepted at full occupancy when a pop happens in the same cycle.
module clause_fifo
  import sat_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  clause_t          i_data,
  input  logic             i_pop,
  output clause_t          o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_push_done,
  output logic             o_pop_done
);

  clause_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop & ~w_empty & ~i_flush;
  assign w_push  = i_push & ~i_flush & ((r_count != CNT_W'(DEPTH)) | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_head <= r_head + PTR_W'(1);
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage is not reset; only occupancy decides what is valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_tail] <= i_data;
  end

  assign o_data      = r_mem[r_head];
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_push_done = w_push & ~i_rst;
  assign o_pop_done  = w_pop & ~i_rst;

endmodule

// File: rtl/engine_clause_rx.sv
// Per-engine clause receiver: buffers granted clauses, raises full one slot early,
// and tracks dropped grants (sticky overflow) and clauses handed to the engine.
module engine_clause_rx
  import sat_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                grant_in,
  input  logic [CLAUSE_W-1:0] clause_in,
  output logic                full_out,
  input  logic                flush_in,
  output logic [CLAUSE_W-1:0] clause_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                empty_out,
  output logic [CNT_W-1:0]    count_out,
  output logic                overflow_out,
  output logic [15:0]         popped_cnt_out
);

  clause_t          w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic             w_push_done;
  logic             w_pop_done;
  logic             r_overflow;
  logic [15:0]      r_popped;

  clause_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_flush     (flush_in),
    .i_push      (grant_in),
    .i_data      (clause_in),
    .i_pop       (ready_in),
    .o_data      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_push_done (w_push_done),
    .o_pop_done  (w_pop_done)
  );

  always_ff @(posedge clock) begin
    if (reset || flush_in) begin
      r_overflow <= 1'b0;
    end else if (grant_in && !w_push_done) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_popped <= '0;
    end else if (w_pop_done && (r_popped != 16'hFFFF)) begin
      r_popped <= r_popped + 16'd1;
    end
  end

  // Reserve one slot for a grant already in flight when full rises.
  assign full_out       = (w_count >= CNT_W'(DEPTH - 1));
  assign clause_out     = w_head;
  assign valid_out      = ~w_empty;
  assign empty_out      = w_empty;
  assign count_out      = w_count;
  assign overflow_out   = r_overflow;
  assign popped_cnt_out = r_popped;

endmodule

// File: tb/tb_engine_clause_rx.sv
// Self-checking bench for engine_clause_rx: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_engine_clause_rx;
  import sat_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned W     = CLAUSE_W;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             grant_in = 1'b0;
  logic [W-1:0]     clause_in = '0;
  logic             full_out;
  logic             flush_in = 1'b0;
  logic [W-1:0]     clause_out;
  logic             valid_out;
  logic             ready_in = 1'b0;
  logic             empty_out;
  logic [CNT_W-1:0] count_out;
  logic             overflow_out;
  logic [15:0]      popped_cnt_out;

  always #5 clock = ~clock;

  engine_clause_rx #(
    .DEPTH(DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .grant_in       (grant_in),
    .clause_in      (clause_in),
    .full_out       (full_out),
    .flush_in       (flush_in),
    .clause_out     (clause_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .empty_out      (empty_out),
    .count_out      (count_out),
    .overflow_out   (overflow_out),
    .popped_cnt_out (popped_cnt_out)
  );

  typedef struct {
    bit           grant;
    logic [W-1:0] clause;
    bit           ready;
    bit           flush;
    bit           rst;
    int           exp_count;
    bit           exp_valid;
    logic [W-1:0] exp_clause;
    bit           exp_full;
    bit           exp_ovf;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain queue of clauses plus flags.
  logic [W-1:0] mq[$];
  bit           m_ovf = 1'b0;
  int           m_popped = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", 64'(count_out), 64'(mq.size()));
    chk("valid", 64'(valid_out), 64'(mq.size() != 0));
    chk("empty", 64'(empty_out), 64'(mq.size() == 0));
    chk("full", 64'(full_out), 64'(mq.size() >= DEPTH - 1));
    chk("overflow", 64'(overflow_out), 64'(m_ovf));
    chk("popped", 64'(popped_cnt_out), 64'(m_popped));
    if (mq.size() != 0) chk("clause", 64'(clause_out), 64'(mq[0]));
  endtask

  task automatic step(input bit g, input logic [W-1:0] c, input bit rd, input bit fl,
                      input bit rs);
    int sz;
    bit popd;
    @(negedge clock);
    grant_in  = g;
    clause_in = c;
    ready_in  = rd;
    flush_in  = fl;
    reset     = rs;
    @(posedge clock);
    if (rs) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_popped = 0;
    end else if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      sz   = mq.size();
      popd = rd && (sz > 0);
      if (popd) begin
        void'(mq.pop_front());
        if (m_popped < 65535) m_popped++;
      end
      if (g) begin
        if (sz < DEPTH || popd) mq.push_back(c);
        else m_ovf = 1'b1;
      end
    end
    #1;
    check_model();
  endtask

  function automatic vec_t mkv(bit g, int c, bit rd, bit fl, bit rs, int ec, bit ev, int eclause,
                               bit ef, bit eo);
    vec_t v;
    v.grant = g; v.clause = W'(c); v.ready = rd; v.flush = fl; v.rst = rs;
    v.exp_count = ec; v.exp_valid = ev; v.exp_clause = W'(eclause);
    v.exp_full = ef; v.exp_ovf = eo;
    return v;
  endfunction

  vec_t vecs[$];
  int   popped_before;

  initial begin
    // Basic in-order delivery, then pop on empty is ignored.
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mkv(1, 2, 0, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mkv(1, 3, 0, 0, 0, 3, 1, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 2, 1, 2, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 1, 1, 3, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].grant, vecs[i].clause, vecs[i].ready, vecs[i].flush, vecs[i].rst);
      chk($sformatf("vec%0d_count", i), 64'(count_out), 64'(vecs[i].exp_count));
      chk($sformatf("vec%0d_valid", i), 64'(valid_out), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_full", i), 64'(full_out), 64'(vecs[i].exp_full));
      chk($sformatf("vec%0d_ovf", i), 64'(overflow_out), 64'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_clause", i), 64'(clause_out), 64'(vecs[i].exp_clause));
    end
    chk("popped_after_3", 64'(popped_cnt_out), 64'd3);

    // Fill to full threshold, accept reserved slot, then overflow.
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, W'(100 + i), 0, 0, 0);
    chk("full_at_7", 64'(full_out), 64'd1);
    chk("count_7", 64'(count_out), 64'd7);
    step(1, W'(107), 0, 0, 0);
    chk("count_8", 64'(count_out), 64'd8);
    chk("no_ovf_at_8", 64'(overflow_out), 64'd0);
    step(1, W'(108), 0, 0, 0);
    chk("ovf_set", 64'(overflow_out), 64'd1);
    chk("count_stays_8", 64'(count_out), 64'd8);

    // Simultaneous push and pop at full occupancy.
    step(1, W'(42), 1, 0, 0);
    chk("full_pushpop_count", 64'(count_out), 64'd8);
    chk("full_pushpop_head", 64'(clause_out), 64'd101);
    for (int i = 0; i < 7; i++) step(0, '0, 1, 0, 0);
    chk("clause42_eighth", 64'(clause_out), 64'd42);
    chk("ovf_sticky", 64'(overflow_out), 64'd1);

    // Flush with coincident grant.
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, W'(200 + i), 0, 0, 0);
    popped_before = int'(popped_cnt_out);
    step(1, W'(299), 1, 1, 0);
    chk("flush_count", 64'(count_out), 64'd0);
    chk("flush_valid", 64'(valid_out), 64'd0);
    chk("flush_ovf", 64'(overflow_out), 64'd0);
    chk("flush_full", 64'(full_out), 64'd0);
    chk("flush_popped", 64'(popped_cnt_out), 64'(popped_before));

    // Streaming: each clause appears one cycle after its grant.
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, W'(i), 1, 0, 0);
      chk($sformatf("stream%0d_clause", i), 64'(clause_out), 64'(i));
      chk($sformatf("stream%0d_count", i), 64'(count_out), 64'd1);
    end
    step(0, '0, 1, 0, 0);
    chk("stream_popped", 64'(popped_cnt_out), 64'd20);

    // Reset mid-stream.
    for (int i = 0; i < 4; i++) step(1, W'(300 + i), 0, 0, 0);
    chk("pre_reset_count", 64'(count_out), 64'd4);
    step(1, W'(400), 1, 1, 1);
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_empty", 64'(empty_out), 64'd1);
    chk("rst_popped", 64'(popped_cnt_out), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, W'({$urandom(), $urandom()}),
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3,
           $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
